ram2p_bw: RTL and testbench



---
 rtl/oap_mem_pkg.sv | 30 +++
 rtl/ram2p_array.sv | 31 +++
 rtl/ram2p_bw.sv | 127 ++++++++++++
 tb/tb_ram2p_bw.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/oap_mem_pkg.sv
// rtl/oap_mem_pkg.sv - shared memory constants and byte-merge helper; RD_LATENCY follows RAM2P_OUTREG_EN
package oap_mem_pkg;

    localparam int BYTE_W   = 8;
    localparam int MERGE_DW = 256;
    localparam int MERGE_NB = MERGE_DW / BYTE_W;

`ifdef RAM2P_OUTREG_EN
    localparam int RD_LATENCY = 3;
`else
    localparam int RD_LATENCY = 2;
`endif

    // Callers zero-extend into MERGE_DW and truncate the result back to their own width.
    function automatic logic [MERGE_DW-1:0] byte_merge(
        input logic [MERGE_DW-1:0] old_word,
        input logic [MERGE_DW-1:0] new_word,
        input logic [MERGE_NB-1:0] mask
    );
        logic [MERGE_DW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MERGE_NB; i++) begin
            if (mask[i]) begin
                merged[BYTE_W*i +: BYTE_W] = new_word[BYTE_W*i +: BYTE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram2p_array.sv
// rtl/ram2p_array.sv - DEPTH x DW storage, one byte-masked write port, two async-address read ports, no reset
module ram2p_array
    import oap_mem_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DW-1:0]    wdata,
    input  logic [DW/8-1:0]  wbe,
    input  logic [AW-1:0]    ra_addr,
    output logic [DW-1:0]    ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [DW-1:0]    rb_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= DW'(byte_merge(MERGE_DW'(mem[waddr]), MERGE_DW'(wdata), MERGE_NB'(wbe)));
        end
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];

endmodule

// File: rtl/ram2p_bw.sv
// rtl/ram2p_bw.sv - two-port byte-write RAM top (A r/w, B read-only); RAM2P_OUTREG_EN adds an output register stage
module ram2p_bw
    import oap_mem_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_cs,
    input  logic             a_rnw,
    input  logic [AW-1:0]    a_address,
    input  logic [DW-1:0]    a_din,
    input  logic [DW/8-1:0]  a_be,
    output logic [DW-1:0]    a_dout,
    output logic             a_valid,
    input  logic             b_cs,
    input  logic [AW-1:0]    b_address,
    output logic [DW-1:0]    b_dout,
    output logic             b_valid
);

    localparam int NB = DW / BYTE_W;
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic          a_cs_q, a_rnw_q, b_cs_q;
    logic [AW-1:0] a_addr_q, b_addr_q;
    logic [DW-1:0] a_din_q;
    logic [NB-1:0] a_be_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_cs_q <= 1'b0;
            b_cs_q <= 1'b0;
        end else begin
            a_cs_q <= a_cs;
            b_cs_q <= b_cs;
        end
        a_rnw_q  <= a_rnw;
        a_addr_q <= a_address;
        a_din_q  <= a_din;
        a_be_q   <= a_be;
        b_addr_q <= b_address;
    end

    logic a_in_range, b_in_range, a_rd, a_wr, b_fwd;
    logic [DW-1:0] a_rdata, b_rdata, b_merged, a_word, b_word;

    assign a_in_range = {1'b0, a_addr_q} < DEPTH_V;
    assign b_in_range = {1'b0, b_addr_q} < DEPTH_V;
    assign a_rd  = a_cs_q && a_rnw_q;
    assign a_wr  = a_cs_q && !a_rnw_q && a_in_range && (|a_be_q);
    assign b_fwd = a_wr && (b_addr_q == a_addr_q);

    ram2p_array #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .we      (a_wr && !reset),
        .waddr   (a_addr_q),
        .wdata   (a_din_q),
        .wbe     (a_be_q),
        .ra_addr (a_addr_q),
        .ra_data (a_rdata),
        .rb_addr (b_addr_q),
        .rb_data (b_rdata)
    );

    // Port B sees the same-cycle port A write as if it had already committed.
    assign b_merged = DW'(byte_merge(MERGE_DW'(b_rdata), MERGE_DW'(a_din_q), MERGE_NB'(a_be_q)));
    assign a_word   = a_in_range ? a_rdata : '0;
    assign b_word   = !b_in_range ? '0 : (b_fwd ? b_merged : b_rdata);

    logic [DW-1:0] a_out, b_out;
    logic          a_out_v, b_out_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_out   <= '0;
            b_out   <= '0;
            a_out_v <= 1'b0;
            b_out_v <= 1'b0;
        end else begin
            a_out_v <= a_rd;
            b_out_v <= b_cs_q;
            if (a_rd) begin
                a_out <= a_word;
            end
            if (b_cs_q) begin
                b_out <= b_word;
            end
        end
    end

`ifdef RAM2P_OUTREG_EN
    logic [DW-1:0] a_out2, b_out2;
    logic          a_out2_v, b_out2_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_out2   <= '0;
            b_out2   <= '0;
            a_out2_v <= 1'b0;
            b_out2_v <= 1'b0;
        end else begin
            a_out2_v <= a_out_v;
            b_out2_v <= b_out_v;
            if (a_out_v) begin
                a_out2 <= a_out;
            end
            if (b_out_v) begin
                b_out2 <= b_out;
            end
        end
    end

    assign a_dout  = a_out2;
    assign a_valid = a_out2_v;
    assign b_dout  = b_out2;
    assign b_valid = b_out2_v;
`else
    assign a_dout  = a_out;
    assign a_valid = a_out_v;
    assign b_dout  = b_out;
    assign b_valid = b_out_v;
`endif

endmodule

// File: tb/tb_ram2p_bw.sv
// tb/tb_ram2p_bw.sv - randomized bench for ram2p_bw against a cycle-level reference model (honours RAM2P_OUTREG_EN)
module tb_ram2p_bw;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 4000;
`ifdef RAM2P_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_cs = 1'b0, a_rnw = 1'b1, b_cs = 1'b0;
    logic [AW-1:0] a_address = '0, b_address = '0;
    logic [DW-1:0] a_din = '0;
    logic [3:0]    a_be = '0;
    logic [DW-1:0] a_dout, b_dout;
    logic          a_valid, b_valid;

    always #5 clk = ~clk;

    ram2p_bw #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_cs      (a_cs),
        .a_rnw     (a_rnw),
        .a_address (a_address),
        .a_din     (a_din),
        .a_be      (a_be),
        .a_dout    (a_dout),
        .a_valid   (a_valid),
        .b_cs      (b_cs),
        .b_address (b_address),
        .b_dout    (b_dout),
        .b_valid   (b_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: memory contents plus expected output events keyed by cycle.
    logic [31:0] mem [0:4095];
    bit          ev_av [8];
    bit          ev_bv [8];
    bit          ev_clr[8];
    logic [31:0] ev_ad [8];
    logic [31:0] ev_bd [8];
    logic [31:0] cur_a, cur_b;
    bit          pend = 0;
    int          pend_addr;
    logic [31:0] pend_din;
    logic [3:0]  pend_be;
    int          cyc = 0;
    bit          chk_en = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) o[8*i +: 8] = n[8*i +: 8];
        end
        return o;
    endfunction

    task automatic step(input bit rst, input bit acs, input bit arnw, input int aaddr,
                        input logic [31:0] adin, input logic [3:0] abe, input bit bcs, input int baddr);
        int s, t;
        @(posedge clk);
        #1;
        s = cyc % 8;
        if (chk_en) begin
            if (ev_clr[s]) begin
                cur_a = '0;
                cur_b = '0;
            end
            if (ev_av[s]) cur_a = ev_ad[s];
            if (ev_bv[s]) cur_b = ev_bd[s];
            check("a_valid", 64'(a_valid), 64'(ev_av[s]));
            check("a_dout", 64'(a_dout), 64'(cur_a));
            check("b_valid", 64'(b_valid), 64'(ev_bv[s]));
            check("b_dout", 64'(b_dout), 64'(cur_b));
        end
        ev_av[s] = 0; ev_bv[s] = 0; ev_clr[s] = 0;
        chk_en = 1;

        reset     = rst;
        a_cs      = acs;
        a_rnw     = arnw;
        a_address = AW'(aaddr);
        a_din     = adin;
        a_be      = abe;
        b_cs      = bcs;
        b_address = AW'(baddr);

        // A write from the previous cycle lands now unless reset is up at its commit edge.
        if (pend && !rst) mem[pend_addr] = merge(mem[pend_addr], pend_din, pend_be);
        pend = 0;
        if (rst) begin
            for (int j = 1; j <= LAT; j++) begin
                ev_av[(cyc + j) % 8] = 0;
                ev_bv[(cyc + j) % 8] = 0;
            end
            ev_clr[(cyc + 1) % 8] = 1;
        end else begin
            t = (cyc + LAT) % 8;
            if (acs && arnw) begin
                ev_av[t] = 1;
                ev_ad[t] = (aaddr < DEPTH) ? mem[aaddr] : 32'h0;
            end
            if (acs && !arnw && aaddr < DEPTH && abe != 4'h0) begin
                pend = 1; pend_addr = aaddr; pend_din = adin; pend_be = abe;
            end
            if (bcs) begin
                ev_bv[t] = 1;
                if (baddr >= DEPTH) ev_bd[t] = 32'h0;
                else if (pend && pend_addr == baddr) ev_bd[t] = merge(mem[baddr], pend_din, pend_be);
                else ev_bd[t] = mem[baddr];
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 32'h0, 4'h0, 0, 0);
    endtask

    task automatic wr(input int addr, input logic [31:0] d, input logic [3:0] be);
        step(0, 1, 0, addr, d, be, 0, 0);
    endtask

    task automatic rd_a(input int addr);
        step(0, 1, 1, addr, 32'h0, 4'h0, 0, 0);
    endtask

    initial begin
        step(1, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        step(1, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        idle(1);
        check("reset_a_dout", 64'(a_dout), 64'h0);
        check("reset_b_valid", 64'(b_valid), 64'h0);

        for (int i = 0; i < DEPTH; i++) wr(i, $urandom, 4'hF);
        idle(2);

        // Write then immediate read of the same address.
        wr(5, 32'hDEADBEEF, 4'hF);
        rd_a(5);
        idle(LAT);
        check("s1_a_dout", 64'(a_dout), 64'hDEADBEEF);
        check("s1_a_valid", 64'(a_valid), 64'h1);
        idle(1);
        check("s1_a_valid_pulse", 64'(a_valid), 64'h0);

        // Partial write forwarded to a same-cycle port B read.
        wr(9, 32'h11223344, 4'hF);
        idle(1);
        step(0, 1, 0, 9, 32'hAABBCCDD, 4'b0101, 1, 9);
        idle(LAT);
        check("s2_b_dout", 64'(b_dout), 64'h11BB33DD);
        rd_a(9);
        idle(LAT);
        check("s2_a_dout", 64'(a_dout), 64'h11BB33DD);

        // Back-to-back reads on both ports.
        wr(3, 32'h03030303, 4'hF);
        wr(7, 32'h07070707, 4'hF);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 3, 32'h0, 4'h0, 1, 7);
        check("s3_a_stream", 64'({a_valid, a_dout}), 64'h1_03030303);
        check("s3_b_stream", 64'({b_valid, b_dout}), 64'h1_07070707);
        idle(LAT);

        // Out-of-range write and read.
        wr(DEPTH, 32'h12345678, 4'hF);
        rd_a(DEPTH);
        idle(LAT);
        check("s4_oor_dout", 64'(a_dout), 64'h0);
        check("s4_oor_valid", 64'(a_valid), 64'h1);
        rd_a(DEPTH - 1);
        rd_a(0);
        idle(LAT);

        // Reset lands on the commit edge of a pending write.
        wr(2, 32'hCAFE0002, 4'hF);
        idle(1);
        wr(2, 32'h55555555, 4'hF);
        step(1, 1, 1, 2, 32'h0, 4'h0, 1, 2);
        idle(1);
        check("s5_rst_a", 64'({a_valid, a_dout}), 64'h0);
        check("s5_rst_b", 64'({b_valid, b_dout}), 64'h0);
        rd_a(2);
        idle(LAT);
        check("s5_kept", 64'(a_dout), 64'hCAFE0002);

        // Randomized traffic with address collisions, out-of-range accesses and rare resets.
        for (int n = 0; n < 4000; n++) begin
            int aa, ba, sel;
            sel = $urandom_range(0, 31);
            aa = (sel < 8) ? $urandom_range(0, 7) : (sel == 31) ? $urandom_range(DEPTH, 4095) : $urandom_range(0, DEPTH - 1);
            sel = $urandom_range(0, 31);
            ba = (sel < 8) ? $urandom_range(0, 7) : (sel == 31) ? $urandom_range(DEPTH, 4095) : $urandom_range(0, DEPTH - 1);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, aa,
                 $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) != 0, ba);
        end
        idle(LAT + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
